// File: rtl/mode_seq_if.sv
// Handshake bundle between the scan/switch side and the mode sequencer.
// master drives switches and frame pulses; slave (the sequencer) drives mode controls.
interface mode_seq_if;
    logic [3:0]  sw_mode;
    logic        frame_start;
    logic [3:0]  mode;
    logic [10:0] latency;
    logic [4:0]  stage_en;
    logic        out_blank;
    logic        busy;

    modport master (
        output sw_mode,
        output frame_start,
        input  mode,
        input  latency,
        input  stage_en,
        input  out_blank,
        input  busy
    );

    modport slave (
        input  sw_mode,
        input  frame_start,
        output mode,
        output latency,
        output stage_en,
        output out_blank,
        output busy
    );
endinterface

// File: rtl/mode_sequencer.sv
// Debounced, frame-aligned processing-mode selection with post-change output blanking.
// Optional auto-cycle of modes 1..5 when switches read 4'hF: define MODE_SEQ_AUTO_CYCLE_EN.
module mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int FLUSH_FRAMES    = 2,
    parameter int AUTO_PERIOD     = 120
) (
    input  logic        clk,
    input  logic        rst,
    mode_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_FRAMES);

    function automatic logic [10:0] lat_of(input logic [3:0] m);
        case (m)
            4'd0:    lat_of = 11'd3;
            4'd1:    lat_of = 11'd6;
            4'd2:    lat_of = 11'd9;
            4'd3:    lat_of = 11'd13;
            4'd4:    lat_of = 11'd15;
            4'd5:    lat_of = 11'd17;
            default: lat_of = 11'd3;
        endcase
    endfunction

    function automatic logic [4:0] stage_of(input logic [3:0] m);
        logic [4:0] s;
        s = 5'd0;
        for (int k = 0; k < 5; k++) begin
            s[k] = (m >= 4'(k + 1));
        end
        return s;
    endfunction

    logic [3:0]       sw_meta_q;
    logic [3:0]       sw_sync_q;
    logic [3:0]       sw_clean;
    logic [3:0]       cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       deb_q;
    logic             fs_prev_q;
    logic             fs_rise;

    state_t      state_q;
    logic [3:0]  mode_q;
    logic [10:0] latency_q;
    logic [4:0]  stage_q;
    logic        blank_q;
    logic        busy_q;
    logic [3:0]  flush_cnt_q;

    assign sw_clean = (sw_sync_q > 4'd5) ? 4'd0 : sw_sync_q;
    assign fs_rise  = bus.frame_start & ~fs_prev_q;

    // Two-flop synchronizer for the asynchronous switch bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= 4'd0;
            sw_sync_q <= 4'd0;
        end else begin
            sw_meta_q <= bus.sw_mode;
            sw_sync_q <= sw_meta_q;
        end
    end

`ifdef MODE_SEQ_AUTO_CYCLE_EN
    localparam int              AUTO_W    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
    logic [AUTO_W-1:0] frame_cnt_q;
    logic [3:0]        auto_q;

    // Debounce, with 4'hF overriding the target by a frame-paced 1..5 sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            deb_q       <= 4'd0;
            frame_cnt_q <= '0;
            auto_q      <= 4'd1;
        end else if (sw_sync_q == 4'hF) begin
            // Leaving auto mode must re-qualify through the normal debounce path.
            cand_q <= 4'd0;
            cnt_q  <= '0;
            deb_q  <= auto_q;
            if (fs_rise) begin
                if (frame_cnt_q == AUTO_LAST) begin
                    frame_cnt_q <= '0;
                    auto_q      <= (auto_q == 4'd5) ? 4'd1 : auto_q + 4'd1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + AUTO_W'(1);
                end
            end else begin
                frame_cnt_q <= frame_cnt_q;
            end
        end else begin
            frame_cnt_q <= '0;
            auto_q      <= 4'd1;
            if (sw_clean != cand_q) begin
                cand_q <= sw_clean;
                cnt_q  <= '0;
            end else if (cnt_q == DEB_LAST) begin
                deb_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
`else
    // Debounce: the candidate must hold for DEBOUNCE_CYCLES before it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q <= 4'd0;
            cnt_q  <= '0;
            deb_q  <= 4'd0;
        end else if (sw_clean != cand_q) begin
            cand_q <= sw_clean;
            cnt_q  <= '0;
        end else if (cnt_q == DEB_LAST) begin
            deb_q <= cand_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`endif

    // Mode FSM: commits only on a frame edge, then blanks while line buffers refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            mode_q      <= 4'd0;
            latency_q   <= 11'd3;
            stage_q     <= 5'd0;
            blank_q     <= 1'b1;
            busy_q      <= 1'b1;
            flush_cnt_q <= FLUSH_INIT;
            fs_prev_q   <= 1'b0;
        end else begin
            fs_prev_q <= bus.frame_start;
            case (state_q)
                ST_RUN: begin
                    blank_q <= 1'b0;
                    if (deb_q != mode_q) begin
                        state_q <= ST_PEND;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (fs_rise && (deb_q != mode_q)) begin
                        state_q     <= ST_FLUSH;
                        mode_q      <= deb_q;
                        latency_q   <= lat_of(deb_q);
                        stage_q     <= stage_of(deb_q);
                        flush_cnt_q <= FLUSH_INIT;
                        blank_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (fs_rise) begin
                        state_q <= ST_RUN;
                        blank_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        blank_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (fs_rise && (flush_cnt_q <= 4'd1)) begin
                        flush_cnt_q <= 4'd0;
                        blank_q     <= 1'b0;
                        if (deb_q != mode_q) begin
                            state_q <= ST_PEND;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end
                    end else if (fs_rise) begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end else begin
                        blank_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_FLUSH;
                    mode_q      <= 4'd0;
                    latency_q   <= 11'd3;
                    stage_q     <= 5'd0;
                    blank_q     <= 1'b1;
                    busy_q      <= 1'b1;
                    flush_cnt_q <= FLUSH_INIT;
                end
            endcase
        end
    end

    assign bus.mode      = mode_q;
    assign bus.latency   = latency_q;
    assign bus.stage_en  = stage_q;
    assign bus.out_blank = blank_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed plus randomized checks of mode_sequencer against a frame-level behavioural model.
module tb_mode_sequencer;

    localparam int DEB    = 1000;
    localparam int SETTLE = DEB + 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cur_mode = 0;
    int   lat_tab [6] = '{3, 6, 9, 13, 15, 17};

    always #5 clk = ~clk;

    mode_seq_if bus ();

    mode_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .FLUSH_FRAMES    (2),
        .AUTO_PERIOD     (120)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int m, input int blank, input int bsy);
        check({tag, ".mode"},    32'(bus.mode),      32'(m));
        check({tag, ".latency"}, 32'(bus.latency),   32'(lat_tab[m]));
        check({tag, ".stage"},   32'(bus.stage_en),  32'((1 << m) - 1));
        check({tag, ".blank"},   32'(bus.out_blank), 32'(blank));
        check({tag, ".busy"},    32'(bus.busy),      32'(bsy));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    // Model: a code held well past the debounce window becomes the target (codes >5 read as 0);
    // it commits on the next frame and blanks for two frames.
    task automatic apply_code(input int code);
        int exp_m;
        bus.sw_mode = 4'(code);
        cycles(SETTLE);
        exp_m = (code > 5) ? 0 : code;
        if (exp_m != cur_mode) begin
            check_all($sformatf("pend%0d", code), cur_mode, 0, 1);
            pulse();
            cur_mode = exp_m;
            check_all($sformatf("commit%0d", code), cur_mode, 1, 1);
            pulse();
            check_all($sformatf("flush%0d", code), cur_mode, 1, 1);
            pulse();
            check_all($sformatf("run%0d", code), cur_mode, 0, 0);
        end else begin
            check_all($sformatf("idle%0d", code), cur_mode, 0, 0);
            pulse();
            check_all($sformatf("idlef%0d", code), cur_mode, 0, 0);
        end
    endtask

    initial begin
        bus.sw_mode     = 4'd0;
        bus.frame_start = 1'b0;
        cycles(3);
        check_all("reset", 0, 1, 1);
        rst = 1'b0;
        cycles(5);
        check_all("boot_hold", 0, 1, 1);
        pulse();
        check_all("boot_f1", 0, 1, 1);
        pulse();
        check_all("boot_f2", 0, 0, 0);

        apply_code(3);
        apply_code(9);

        // Bouncing switches never settle, so nothing should happen.
        for (int i = 0; i < 200; i++) begin
            bus.sw_mode = (i % 2 == 1) ? 4'd2 : 4'd0;
            cycles(100);
            check("bounce.busy", 32'(bus.busy), 32'd0);
            check("bounce.mode", 32'(bus.mode), 32'd0);
        end
        bus.sw_mode = 4'd0;
        cycles(SETTLE);
        check_all("bounce_end", 0, 0, 0);

        // Target retargeted while pending: latest debounced value is the one committed.
        bus.sw_mode = 4'd5;
        cycles(SETTLE);
        check_all("pend_to5", 0, 0, 1);
        bus.sw_mode = 4'd1;
        cycles(SETTLE);
        check_all("pend_to1", 0, 0, 1);
        pulse();
        cur_mode = 1;
        check_all("retarget", 1, 1, 1);
        pulse();
        pulse();
        check_all("retarget_run", 1, 0, 0);

        // Switch reverted before the frame: back to RUN without blanking.
        bus.sw_mode = 4'd3;
        cycles(SETTLE);
        check_all("revert_pend", 1, 0, 1);
        bus.sw_mode = 4'd1;
        cycles(SETTLE);
        check_all("revert_wait", 1, 0, 1);
        pulse();
        check_all("reverted", 1, 0, 0);

        // A frame_start held for several cycles is a single frame event.
        bus.sw_mode = 4'd2;
        cycles(SETTLE);
        pulse();
        cur_mode = 2;
        check_all("held_commit", 2, 1, 1);
        @(negedge clk);
        bus.frame_start = 1'b1;
        cycles(4);
        bus.frame_start = 1'b0;
        check_all("held_one", 2, 1, 1);
        pulse();
        check_all("held_run", 2, 0, 0);

        for (int r = 0; r < 12; r++) begin
            apply_code(int'($urandom_range(0, 15)));
        end

        // Reset in the middle of a flush forces the boot state immediately.
        if (cur_mode == 4) apply_code(0);
        bus.sw_mode = 4'd4;
        cycles(SETTLE);
        pulse();
        cur_mode = 4;
        check_all("pre_rst", 4, 1, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all("rst_mid", 0, 1, 1);
        cycles(3);
        check_all("rst_hold", 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
